// File: rtl/timer_preset_editor_pkg.sv
// rtl/timer_preset_editor_pkg.sv - shared states, key indices and BCD limits for the preset editor
package timer_preset_editor_pkg;

  // State codes double as the edit_field output encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT_H = 2'd1,
    ST_EDIT_M = 2'd2,
    ST_EDIT_S = 2'd3
  } state_e;

  localparam logic [7:0] BCD_HOUR_MAX   = 8'h23;
  localparam logic [7:0] BCD_MINSEC_MAX = 8'h59;

  localparam logic [7:0] DEF_HOUR   = 8'h00;
  localparam logic [7:0] DEF_MINUTE = 8'h00;
  localparam logic [7:0] DEF_SECOND = 8'h30;

  localparam int KEY_MODE = 0;
  localparam int KEY_UP   = 1;
  localparam int KEY_DOWN = 2;
  localparam int KEY_OK   = 3;

endpackage

// File: rtl/timer_preset_editor_key_debounce.sv
// rtl/timer_preset_editor_key_debounce.sv - key synchroniser, tick debouncer, press pulse and auto-repeat
module timer_preset_editor_key_debounce #(
  parameter int DEBOUNCE_MS = 20,
  parameter int REPEAT_DLY  = 500,
  parameter int REPEAT_MS   = 100,
  parameter bit REPEAT_EN   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_raw,
  output logic press
);

  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_MS - 1);
  localparam logic [15:0] DLY_LAST = 16'(REPEAT_DLY - 1);
  localparam logic [15:0] RPT_LAST = 16'(REPEAT_MS - 1);

  logic [1:0]  sync_q, sync_d;
  logic        level_q, level_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic [15:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_arm_q, rpt_arm_d;
  logic        press_q, press_d;
  logic        fire;

  always_comb begin
    sync_d    = {sync_q[0], key_raw};
    level_d   = level_q;
    deb_cnt_d = deb_cnt_q;
    if (tick) begin
      if (sync_q[1] != level_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          level_d   = ~level_q;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 16'd1;
        end
      end else begin
        deb_cnt_d = '0;
      end
    end

    // First repeat waits REPEAT_DLY ticks, later ones REPEAT_MS ticks.
    fire      = 1'b0;
    rpt_cnt_d = rpt_cnt_q;
    rpt_arm_d = rpt_arm_q;
    if (!REPEAT_EN || !level_q) begin
      rpt_cnt_d = '0;
      rpt_arm_d = 1'b0;
    end else if (tick) begin
      if (rpt_cnt_q == (rpt_arm_q ? RPT_LAST : DLY_LAST)) begin
        fire      = 1'b1;
        rpt_cnt_d = '0;
        rpt_arm_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 16'd1;
      end
    end

    press_d = (level_d & ~level_q) | fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      level_q   <= 1'b0;
      deb_cnt_q <= '0;
      rpt_cnt_q <= '0;
      rpt_arm_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      level_q   <= level_d;
      deb_cnt_q <= deb_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      rpt_arm_q <= rpt_arm_d;
      press_q   <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/timer_preset_editor.sv
// rtl/timer_preset_editor.sv - key-driven HH:MM:SS BCD preset editor with commit and blink strobe
module timer_preset_editor
  import timer_preset_editor_pkg::*;
#(
  parameter int         CLK_DIV     = 50000,
  parameter int         DEBOUNCE_MS = 20,
  parameter int         REPEAT_DLY  = 500,
  parameter int         REPEAT_MS   = 100,
  parameter int         BLINK_MS    = 250,
  parameter logic [7:0] DEF_H       = DEF_HOUR,
  parameter logic [7:0] DEF_M       = DEF_MINUTE,
  parameter logic [7:0] DEF_S       = DEF_SECOND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_ok,
  output logic [7:0] preset_hour_bcd,
  output logic [7:0] preset_minute_bcd,
  output logic [7:0] preset_second_bcd,
  output logic [7:0] work_hour_bcd,
  output logic [7:0] work_minute_bcd,
  output logic [7:0] work_second_bcd,
  output logic [1:0] edit_field,
  output logic       blink,
  output logic       commit
);

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_MS - 1);

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] max_v,
                                          input logic up);
    logic [7:0] r;
    if (up) begin
      if (v == max_v)            r = 8'h00;
      else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
      else                       r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v == 8'h00)            r = max_v;
      else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
      else                       r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  logic [15:0] div_cnt_q, div_cnt_d;
  logic        tick;
  logic [3:0]  key_raw;
  logic [3:0]  press;

  assign tick      = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
  assign key_raw   = {key_ok, key_down, key_up, key_mode};

  for (genvar i = 0; i < 4; i++) begin : g_key
    timer_preset_editor_key_debounce #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_MS   (REPEAT_MS),
      .REPEAT_EN   (i == KEY_UP || i == KEY_DOWN)
    ) u_key (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .key_raw (key_raw[i]),
      .press   (press[i])
    );
  end

  state_e      state_q, state_d;
  logic [7:0]  work_h_q, work_h_d, work_m_q, work_m_d, work_s_q, work_s_d;
  logic [7:0]  pre_h_q, pre_h_d, pre_m_q, pre_m_d, pre_s_q, pre_s_d;
  logic        commit_q, commit_d;
  logic        blink_q, blink_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_restart;
  logic        mode_p, up_p, down_p, ok_p;

  assign mode_p = press[KEY_MODE];
  assign up_p   = press[KEY_UP];
  assign down_p = press[KEY_DOWN];
  assign ok_p   = press[KEY_OK];

  always_comb begin
    state_d       = state_q;
    work_h_d      = work_h_q;
    work_m_d      = work_m_q;
    work_s_d      = work_s_q;
    pre_h_d       = pre_h_q;
    pre_m_d       = pre_m_q;
    pre_s_d       = pre_s_q;
    commit_d      = 1'b0;
    blink_restart = 1'b0;

    if (state_q == ST_IDLE) begin
      if (mode_p) begin
        work_h_d      = pre_h_q;
        work_m_d      = pre_m_q;
        work_s_d      = pre_s_q;
        state_d       = ST_EDIT_H;
        blink_restart = 1'b1;
      end
    end else begin
      // Field step uses the field selected this cycle, even if mode/ok also fire.
      if (up_p ^ down_p) begin
        if (state_q == ST_EDIT_H)      work_h_d = bcd_step(work_h_q, BCD_HOUR_MAX, up_p);
        else if (state_q == ST_EDIT_M) work_m_d = bcd_step(work_m_q, BCD_MINSEC_MAX, up_p);
        else                           work_s_d = bcd_step(work_s_q, BCD_MINSEC_MAX, up_p);
      end
      if (ok_p) begin
        pre_h_d  = work_h_q;
        pre_m_d  = work_m_q;
        pre_s_d  = work_s_q;
        commit_d = 1'b1;
        state_d  = ST_IDLE;
      end else if (mode_p) begin
        state_d       = (state_q == ST_EDIT_S) ? ST_EDIT_H : state_e'(state_q + 2'd1);
        blink_restart = 1'b1;
      end
    end

    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (state_d == ST_IDLE) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (blink_restart) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      work_h_q    <= DEF_H;
      work_m_q    <= DEF_M;
      work_s_q    <= DEF_S;
      pre_h_q     <= DEF_H;
      pre_m_q     <= DEF_M;
      pre_s_q     <= DEF_S;
      commit_q    <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      state_q     <= state_d;
      work_h_q    <= work_h_d;
      work_m_q    <= work_m_d;
      work_s_q    <= work_s_d;
      pre_h_q     <= pre_h_d;
      pre_m_q     <= pre_m_d;
      pre_s_q     <= pre_s_d;
      commit_q    <= commit_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign preset_hour_bcd   = pre_h_q;
  assign preset_minute_bcd = pre_m_q;
  assign preset_second_bcd = pre_s_q;
  assign work_hour_bcd     = work_h_q;
  assign work_minute_bcd   = work_m_q;
  assign work_second_bcd   = work_s_q;
  assign edit_field        = state_q;
  assign blink             = blink_q;
  assign commit            = commit_q;

endmodule

// File: tb/tb_timer_preset_editor.sv
// tb/tb_timer_preset_editor.sv - directed and randomized checks of the preset editor against a field-level model
module tb_timer_preset_editor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0, key_up = 1'b0, key_down = 1'b0, key_ok = 1'b0;
  logic [7:0] preset_hour_bcd, preset_minute_bcd, preset_second_bcd;
  logic [7:0] work_hour_bcd, work_minute_bcd, work_second_bcd;
  logic [1:0] edit_field;
  logic       blink, commit;

  timer_preset_editor #(
    .CLK_DIV(10), .DEBOUNCE_MS(4), .REPEAT_DLY(20), .REPEAT_MS(5), .BLINK_MS(8)
  ) dut (
    .clk(clk), .rst(rst),
    .key_mode(key_mode), .key_up(key_up), .key_down(key_down), .key_ok(key_ok),
    .preset_hour_bcd(preset_hour_bcd), .preset_minute_bcd(preset_minute_bcd),
    .preset_second_bcd(preset_second_bcd),
    .work_hour_bcd(work_hour_bcd), .work_minute_bcd(work_minute_bcd),
    .work_second_bcd(work_second_bcd),
    .edit_field(edit_field), .blink(blink), .commit(commit)
  );

  always #5 clk = ~clk;

  int tests = 0, failed = 0;
  int cyc = 0, commit_cnt = 0;
  int mst = 0, exp_commits = 0;
  int mw[3], mp[3];
  int stamps[$];
  int chg = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (commit === 1'b1) commit_cnt <= commit_cnt + 1;
  end

  function automatic logic [7:0] tobcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int maxv(input int f);
    return (f == 0) ? 23 : 59;
  endfunction

  function automatic int mstep(input int v, input int f, input bit up);
    if (up) return (v == maxv(f)) ? 0 : v + 1;
    return (v == 0) ? maxv(f) : v - 1;
  endfunction

  function automatic logic [7:0] wf(input int f);
    case (f)
      0:       return work_hour_bcd;
      1:       return work_minute_bcd;
      default: return work_second_bcd;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mst = 0;
    mw[0] = 0; mw[1] = 0; mw[2] = 30;
    mp[0] = 0; mp[1] = 0; mp[2] = 30;
  endtask

  task automatic model_key(input int k);
    case (k)
      0: if (mst == 0) begin mw = mp; mst = 1; end else mst = (mst == 3) ? 1 : mst + 1;
      1: if (mst != 0) mw[mst-1] = mstep(mw[mst-1], mst - 1, 1'b1);
      2: if (mst != 0) mw[mst-1] = mstep(mw[mst-1], mst - 1, 1'b0);
      default: if (mst != 0) begin mp = mw; mst = 0; exp_commits++; end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".field"}, 32'(edit_field), 32'(mst));
    check({tag, ".work_h"}, 32'(work_hour_bcd), 32'(tobcd(mw[0])));
    check({tag, ".work_m"}, 32'(work_minute_bcd), 32'(tobcd(mw[1])));
    check({tag, ".work_s"}, 32'(work_second_bcd), 32'(tobcd(mw[2])));
    check({tag, ".pre_h"}, 32'(preset_hour_bcd), 32'(tobcd(mp[0])));
    check({tag, ".pre_m"}, 32'(preset_minute_bcd), 32'(tobcd(mp[1])));
    check({tag, ".pre_s"}, 32'(preset_second_bcd), 32'(tobcd(mp[2])));
    check({tag, ".commits"}, 32'(commit_cnt), 32'(exp_commits));
    if (mst == 0) check({tag, ".blink_idle"}, 32'(blink), 32'd0);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_mode = v;
      1: key_up = v;
      2: key_down = v;
      default: key_ok = v;
    endcase
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Short press: long enough to debounce, far shorter than the repeat delay.
  task automatic press(input int k, input string tag);
    set_key(k, 1'b1);
    cycles(60);
    set_key(k, 1'b0);
    cycles(70);
    model_key(k);
    check_all(tag);
  endtask

  task automatic set_field(input int f, input int target);
    int d;
    for (int n = 0; n < 60 && mw[f] != target; n++) begin
      d = (target - mw[f] + maxv(f) + 1) % (maxv(f) + 1);
      press((d <= (maxv(f) + 1) / 2) ? 1 : 2, "set_field");
    end
  endtask

  // Follow a held up/down key: every observed change must be the next model step.
  task automatic watch(input int f, input bit up, input int ncyc, input int maxchg);
    logic [7:0] prev;
    prev = wf(f);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (wf(f) !== prev) begin
        mw[f] = mstep(mw[f], f, up);
        check("hold_step", 32'(wf(f)), 32'(tobcd(mw[f])));
        stamps.push_back(cyc);
        chg++;
        prev = wf(f);
        if (maxchg != 0 && chg >= maxchg) break;
      end
    end
  endtask

  initial begin
    int n;
    bit seen;
    model_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(2);
    check_all("reset");
    check("reset.blink", 32'(blink), 32'd0);
    check("reset.commit", 32'(commit), 32'd0);

    press(1, "idle_up");
    press(2, "idle_down");
    press(3, "idle_ok");

    // Chatter on mode, then a clean hold: a single entry into hour editing.
    for (int i = 0; i < 4; i++) begin
      key_mode = ~key_mode;
      cycles(20);
    end
    key_mode = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (edit_field != 2'd0) seen = 1'b1;
    end
    check("chatter.entered", 32'(seen), 32'd1);
    model_key(0);
    check("chatter.blink_on", 32'(blink), 32'd1);
    cycles(85);
    check("chatter.blink_off", 32'(blink), 32'd0);
    key_mode = 1'b0;
    cycles(70);
    check_all("chatter");

    // Hold up through the whole hour range and the 23->00 wrap.
    chg = 0;
    key_up = 1'b1;
    watch(0, 1'b1, 2000, 24);
    check("hour_walk.count", 32'(chg), 32'd24);
    check("hour_walk.wrap", 32'(work_hour_bcd), 32'h00);
    key_up = 1'b0;
    watch(0, 1'b1, 150, 0);
    check_all("hour_walk");

    press(0, "to_min");
    press(0, "to_sec");
    set_field(2, 0);
    press(2, "sec_borrow");
    check("sec_00_down", 32'(work_second_bcd), 32'h59);
    press(1, "sec_wrap_up");
    set_field(2, 9);
    press(1, "sec_carry");
    check("sec_09_up", 32'(work_second_bcd), 32'h10);

    // Auto-repeat cadence on down.
    stamps.delete();
    key_down = 1'b1;
    watch(2, 1'b0, 400, 0);
    key_down = 1'b0;
    watch(2, 1'b0, 150, 0);
    n = stamps.size();
    watch(2, 1'b0, 100, 0);
    check("repeat.stopped", 32'(stamps.size()), 32'(n));
    check("repeat.enough", 32'(n >= 4), 32'd1);
    if (n >= 4) begin
      check("repeat.first_gap", 32'(stamps[1] - stamps[0]), 32'd200);
      check("repeat.gap2", 32'(stamps[2] - stamps[1]), 32'd50);
      check("repeat.gap3", 32'(stamps[3] - stamps[2]), 32'd50);
    end

    press(0, "to_hour");
    set_field(0, 12);
    press(0, "to_min2");
    set_field(1, 34);
    press(0, "to_sec2");
    set_field(2, 56);
    press(3, "commit");
    check("commit.preset", 32'({preset_hour_bcd, preset_minute_bcd, preset_second_bcd}),
          32'h123456);

    press(0, "reedit");
    press(0, "reedit_min");
    press(1, "reedit_up");
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    model_reset();
    cycles(2);
    check_all("mid_reset");

    // Simultaneous ok+mode, then simultaneous up+down.
    press(0, "sim_enter");
    key_ok = 1'b1; key_mode = 1'b1;
    cycles(60);
    key_ok = 1'b0; key_mode = 1'b0;
    cycles(70);
    model_key(3);
    check_all("ok_mode");
    press(0, "sim_enter2");
    key_up = 1'b1; key_down = 1'b1;
    cycles(60);
    key_up = 1'b0; key_down = 1'b0;
    cycles(70);
    check_all("up_down");

    for (int i = 0; i < 40; i++) press(int'($urandom_range(0, 3)), "random");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
